// File: rtl/md5_pkg.sv
// md5_pkg: MD5 round constants, round functions, IV and FSM state type shared by the iterative core.
package md5_pkg;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINAL, S_DONE} state_e;
  localparam logic [31:0] IV_A = 32'h67452301;
  localparam logic [31:0] IV_B = 32'hefcdab89;
  localparam logic [31:0] IV_C = 32'h98badcfe;
  localparam logic [31:0] IV_D = 32'h10325476;
  localparam logic [31:0] K [64] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee, 32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be, 32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa, 32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed, 32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c, 32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05, 32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039, 32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1, 32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };
  localparam logic [4:0] S [64] = '{
    5'd7, 5'd12, 5'd17, 5'd22, 5'd7, 5'd12, 5'd17, 5'd22, 5'd7, 5'd12, 5'd17, 5'd22, 5'd7, 5'd12, 5'd17, 5'd22,
    5'd5, 5'd9,  5'd14, 5'd20, 5'd5, 5'd9,  5'd14, 5'd20, 5'd5, 5'd9,  5'd14, 5'd20, 5'd5, 5'd9,  5'd14, 5'd20,
    5'd4, 5'd11, 5'd16, 5'd23, 5'd4, 5'd11, 5'd16, 5'd23, 5'd4, 5'd11, 5'd16, 5'd23, 5'd4, 5'd11, 5'd16, 5'd23,
    5'd6, 5'd10, 5'd15, 5'd21, 5'd6, 5'd10, 5'd15, 5'd21, 5'd6, 5'd10, 5'd15, 5'd21, 5'd6, 5'd10, 5'd15, 5'd21
  };
  function automatic logic [31:0] f_fn(input logic [5:0] i, input logic [31:0] b, input logic [31:0] c,
                                       input logic [31:0] d);
    return i[5:4] == 2'd0 ? (b & c) | (~b & d) :
           i[5:4] == 2'd1 ? (d & b) | (~d & c) :
           i[5:4] == 2'd2 ? b ^ c ^ d : c ^ (b | ~d);
  endfunction
  // Only the low index bits matter modulo 16, so 4-bit wrapping arithmetic is exact.
  function automatic logic [3:0] g_fn(input logic [5:0] i);
    return i[5:4] == 2'd0 ? i[3:0] :
           i[5:4] == 2'd1 ? 4'd5 * i[3:0] + 4'd1 :
           i[5:4] == 2'd2 ? 4'd3 * i[3:0] + 4'd5 : 4'd7 * i[3:0];
  endfunction
endpackage

// File: rtl/md5_step.sv
// md5_step: one combinational MD5 step; rotates the working variables and mixes in one message word.
module md5_step
  import md5_pkg::*;
(
  input  logic [5:0]  i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] c_i,
  input  logic [31:0] d_i,
  input  logic [31:0] m_i,
  output logic [31:0] a_o,
  output logic [31:0] b_o,
  output logic [31:0] c_o,
  output logic [31:0] d_o
);
  logic [31:0] t;
  logic [31:0] rot;
  always_comb begin
    t = a_i + f_fn(i, b_i, c_i, d_i) + K[i] + m_i;
    rot = (t << S[i]) | (t >> (6'd32 - 6'(S[i])));
    a_o = d_i;
    d_o = c_i;
    c_o = b_i;
    b_o = b_i + rot;
  end
endmodule

// File: rtl/md5_iter_core.sv
// md5_iter_core: iterative MD5 compression of one 512-bit block, UNROLL steps per clock.
module md5_iter_core
  import md5_pkg::*;
#(
  parameter int UNROLL = 1,
  parameter int TAG_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     state_in,
  input  logic [511:0]     m_in,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     digest_out,
  output logic [TAG_W-1:0] tag_out,
  output logic             busy
);
  if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4 && UNROLL != 8 && UNROLL != 16) begin : g_bad_unroll
    $error("md5_iter_core: UNROLL must be 1, 2, 4, 8 or 16");
  end
  state_e state_q, state_d;
  logic [5:0] i_q, i_d;
  logic [31:0] a_q, b_q, c_q, d_q, a_d, b_d, c_d, d_d;
  logic [127:0] st_q, st_d, digest_q, digest_d;
  logic [511:0] m_q, m_d;
  logic [TAG_W-1:0] tag_q, tag_d, tag_out_q, tag_out_d;
  logic [31:0] ca [UNROLL+1];
  logic [31:0] cb [UNROLL+1];
  logic [31:0] cc [UNROLL+1];
  logic [31:0] cd [UNROLL+1];
  logic accept, run, fin, last;
  assign ca[0] = a_q;
  assign cb[0] = b_q;
  assign cc[0] = c_q;
  assign cd[0] = d_q;
  // Each stage picks its own message word from g of its own step index.
  for (genvar u = 0; u < UNROLL; u++) begin : g_step
    logic [5:0] idx;
    assign idx = i_q + 6'(u);
    md5_step u_step (
      .i   (idx),
      .a_i (ca[u]),
      .b_i (cb[u]),
      .c_i (cc[u]),
      .d_i (cd[u]),
      .m_i (m_q[{g_fn(idx), 5'd0} +: 32]),
      .a_o (ca[u+1]),
      .b_o (cb[u+1]),
      .c_o (cc[u+1]),
      .d_o (cd[u+1])
    );
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      i_q       <= '0;
      digest_q  <= '0;
      tag_out_q <= '0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      digest_q  <= digest_d;
      tag_out_q <= tag_out_d;
    end
  end
  always_ff @(posedge clk) begin
    a_q   <= a_d;
    b_q   <= b_d;
    c_q   <= c_d;
    d_q   <= d_d;
    st_q  <= st_d;
    m_q   <= m_d;
    tag_q <= tag_d;
  end
  always_comb begin
    last = i_q == 6'(64 - UNROLL);
    state_d = state_q == S_IDLE  ? (in_valid ? S_RUN : S_IDLE) :
              state_q == S_RUN   ? (last ? S_FINAL : S_RUN) :
              state_q == S_FINAL ? S_DONE : (out_ready ? S_IDLE : S_DONE);
  end
  always_comb begin
    accept = state_q == S_IDLE && in_valid;
    run = state_q == S_RUN;
    fin = state_q == S_FINAL;
    i_d = accept ? 6'd0 : run ? i_q + 6'(UNROLL) : i_q;
    a_d = accept ? state_in[31:0]   : run ? ca[UNROLL] : a_q;
    b_d = accept ? state_in[63:32]  : run ? cb[UNROLL] : b_q;
    c_d = accept ? state_in[95:64]  : run ? cc[UNROLL] : c_q;
    d_d = accept ? state_in[127:96] : run ? cd[UNROLL] : d_q;
    st_d = accept ? state_in : st_q;
    m_d = accept ? m_in : m_q;
    tag_d = accept ? tag_in : tag_q;
    digest_d = fin ? {st_q[127:96] + d_q, st_q[95:64] + c_q, st_q[63:32] + b_q, st_q[31:0] + a_q} : digest_q;
    tag_out_d = fin ? tag_q : tag_out_q;
  end
  always_comb begin
    in_ready = state_q == S_IDLE;
    out_valid = state_q == S_DONE;
    busy = state_q != S_IDLE;
    digest_out = digest_q;
    tag_out = tag_out_q;
  end
endmodule

// File: tb/tb_md5_iter_core.sv
// tb_md5_iter_core: scoreboard bench for the iterative MD5 core with directed and random blocks.
module tb_md5_iter_core;
  localparam logic [127:0] IV      = 128'h10325476_98badcfe_efcdab89_67452301;
  localparam logic [127:0] D_EMPTY = 128'h7e42f8ec980980e904b2008fd98c1dd4;
  localparam logic [127:0] D_ABC   = 128'h727fe128_7d3f96d6_b04fd23c_98500190;
  localparam logic [511:0] M_EMPTY = 512'h80;
  localparam logic [511:0] M_ABC   = {32'h0, 32'h18, {13{32'h0}}, 32'h80636261};
  typedef struct packed {logic [127:0] digest; logic [7:0] tag;} exp_t;
  logic clk = 0, reset = 1, in_valid = 0, out_ready = 0;
  logic [127:0] state_in = '0;
  logic [511:0] m_in = '0;
  logic [7:0] tag_in = '0;
  logic in_ready, out_valid, busy;
  logic [127:0] digest_out;
  logic [7:0] tag_out;
  int checks = 0, errors = 0, cyc = 0, acc_cyc = 0;
  exp_t q[$];
  exp_t mon_e;
  md5_iter_core #(.UNROLL(1), .TAG_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .state_in(state_in),
    .m_in(m_in), .tag_in(tag_in), .out_valid(out_valid), .out_ready(out_ready),
    .digest_out(digest_out), .tag_out(tag_out), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // Independent reference: K derived from sin(), shifts from per-round tables.
  function automatic logic [127:0] md5_model(input logic [127:0] st, input logic [511:0] m);
    logic [31:0] a, b, c, d, f, t, k;
    logic [63:0] tt;
    int g, s;
    int sh [4][4];
    real r;
    sh = '{'{7, 12, 17, 22}, '{5, 9, 14, 20}, '{4, 11, 16, 23}, '{6, 10, 15, 21}};
    {d, c, b, a} = st;
    for (int i = 0; i < 64; i++) begin
      case (i / 16)
        0: begin f = (b & c) | (~b & d); g = i; end
        1: begin f = (d & b) | (~d & c); g = (5 * i + 1) % 16; end
        2: begin f = b ^ c ^ d; g = (3 * i + 5) % 16; end
        default: begin f = c ^ (b | ~d); g = (7 * i) % 16; end
      endcase
      r = $sin(real'(i + 1));
      if (r < 0.0) r = -r;
      k = 32'(longint'($floor(r * 4294967296.0)));
      t = a + f + k + m[32*g +: 32];
      s = sh[i/16][i%4];
      tt = {t, t} << s;
      a = d; d = c; c = b; b = b + tt[63:32];
    end
    return {st[127:96] + d, st[95:64] + c, st[63:32] + b, st[31:0] + a};
  endfunction
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %0h expected none", digest_out);
      end else begin
        mon_e = q.pop_front();
        chk("digest", digest_out, mon_e.digest);
        chk("tag", 128'(tag_out), 128'(mon_e.tag));
      end
    end
  end
  task automatic send(input logic [127:0] st, input logic [511:0] m, input logic [7:0] tag,
                      input logic [127:0] exp, input bit hold);
    int n = 0;
    @(posedge clk);
    #1;
    state_in = st; m_in = m; tag_in = tag; in_valid = 1;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 300);
    if (!in_ready) begin
      chk("accept_timeout", 128'(in_ready), 128'(1));
      in_valid = 0;
      return;
    end
    q.push_back(exp_t'{digest: exp, tag: tag});
    acc_cyc = cyc;
    @(posedge clk);
    #1;
    if (!hold) in_valid = 0;
  endtask
  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!out_valid && n < 300);
  endtask
  for (genvar k = 1; k < 5; k++) begin : g_alt
    localparam int U = 1 << k;
    logic v = 0, ov, ir, bz;
    logic [127:0] dg;
    logic [7:0] tg;
    md5_iter_core #(.UNROLL(U), .TAG_W(8)) u_alt (
      .clk(clk), .reset(reset), .in_valid(v), .in_ready(ir), .state_in(IV), .m_in(M_ABC),
      .tag_in(8'h5A), .out_valid(ov), .out_ready(1'b1), .digest_out(dg), .tag_out(tg), .busy(bz)
    );
    initial begin
      int n = 0;
      repeat (5) @(posedge clk);
      #1 v = 1;
      @(posedge clk);
      #1 v = 0;
      do begin
        @(posedge clk);
        n++;
        @(negedge clk);
      end while (!ov && n < 100);
      chk($sformatf("alt%0d_latency", U), 128'(n), 128'(64 / U + 1));
      chk($sformatf("alt%0d_digest", U), dg, D_ABC);
      chk($sformatf("alt%0d_tag", U), 128'(tg), 128'(8'h5A));
      chk($sformatf("alt%0d_busy", U), 128'(bz), 128'(1));
    end
  end
  initial begin
    logic [127:0] st;
    logic [511:0] m;
    logic [7:0] tg;
    int n, prev;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_digest", digest_out, 128'(0));
    chk("rst_tag", 128'(tag_out), 128'(0));
    out_ready = 1;
    send(IV, M_EMPTY, 8'h11, D_EMPTY, 0);
    wait_valid(n);
    chk("latency_empty", 128'(n), 128'(65));
    send(IV, M_ABC, 8'h5A, D_ABC, 0);
    wait_valid(n);
    chk("latency_abc", 128'(n), 128'(65));
    @(posedge clk);
    #1 out_ready = 0;
    send(IV, M_ABC, 8'hA5, D_ABC, 0);
    wait_valid(n);
    for (int j = 0; j < 10; j++) begin
      @(posedge clk);
      #1;
      if (j == 3) begin
        in_valid = 1; state_in = ~IV; m_in = ~M_ABC; tag_in = 8'hEE;
      end
      if (j == 5) in_valid = 0;
      @(negedge clk);
      chk("bp_out_valid", 128'(out_valid), 128'(1));
      chk("bp_digest", digest_out, D_ABC);
      chk("bp_in_ready", 128'(in_ready), 128'(0));
    end
    @(posedge clk);
    #1 out_ready = 1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_back_idle", 128'(in_ready), 128'(1));
    repeat (3) @(negedge clk);
    chk("bp_no_capture", 128'(busy), 128'(0));
    send(IV, M_ABC, 8'h33, D_ABC, 0);
    repeat (20) @(posedge clk);
    #1 reset = 1;
    @(posedge clk);
    #1 reset = 0;
    void'(q.pop_back());
    @(negedge clk);
    chk("midrst_in_ready", 128'(in_ready), 128'(1));
    chk("midrst_busy", 128'(busy), 128'(0));
    chk("midrst_out_valid", 128'(out_valid), 128'(0));
    send(IV, M_ABC, 8'h44, D_ABC, 0);
    wait_valid(n);
    chk("latency_after_rst", 128'(n), 128'(65));
    prev = 0;
    for (int b = 0; b < 50; b++) begin
      st = {$urandom, $urandom, $urandom, $urandom};
      for (int j = 0; j < 16; j++) m[32*j +: 32] = $urandom;
      tg = 8'($urandom);
      send(st, m, tg, md5_model(st, m), 1);
      if (b > 0) chk("b2b_period", 128'(acc_cyc - prev), 128'(67));
      prev = acc_cyc;
    end
    in_valid = 0;
    n = 0;
    while (q.size() > 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 128'(q.size()), 128'(0));
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
